// File: rtl/lvds_iq_rx.sv
// lvds_iq_rx: serial I/Q frame receiver with alignment tracking.
// Define LVDS_RX_LOCK_CONFIRM_EN to require a second aligned frame before lock.
module lvds_iq_rx #(
    parameter int MAX_GAP_WORDS = 8,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 rx_data,
    output logic [12:0]          sample_i,
    output logic [12:0]          sample_q,
    output logic                 sample_valid,
    output logic                 msg_end,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] sync_err_cnt
);
    localparam int GAP_W = $clog2(MAX_GAP_WORDS + 1);
`ifdef LVDS_RX_LOCK_CONFIRM_EN
    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;
`else
    typedef enum logic [1:0] {HUNT, LOCKED} state_t;
`endif
    state_t               state_q, state_d;
    logic [31:0]          sr_q, sr_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d, gap_inc;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [12:0]          si_q, si_d, sq_q, sq_d;
    logic                 valid_q, valid_d, end_q, end_d;
    logic                 sync_ok, data_frame, end_frame, zero_word, boundary, emit;
    assign sr_d       = {sr_q[30:0], rx_data};
    assign sync_ok    = sr_q[31:30] == 2'b10 && sr_q[15:14] == 2'b01 && !sr_q[0];
    assign data_frame = sync_ok && sr_q[16];
    assign end_frame  = sync_ok && !sr_q[16] && sr_q[29:17] == 13'd0 && sr_q[13:1] == 13'd0;
    assign zero_word  = sr_q == 32'd0;
    assign boundary   = cnt_q == 5'd31;
    assign gap_inc    = gap_q + GAP_W'(1);
    assign sample_i     = si_q;
    assign sample_q     = sq_q;
    assign sample_valid = valid_q;
    assign msg_end      = end_q;
    assign locked       = state_q == LOCKED;
    assign sync_err_cnt = err_q;
    // Alignment FSM: hunt every cycle, then check only at 32-bit boundaries once aligned
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        err_d   = err_q;
        emit    = 1'b0;
        if (!enable) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT: begin
                    if (data_frame || end_frame) begin
                        cnt_d = 5'd0;
`ifdef LVDS_RX_LOCK_CONFIRM_EN
                        state_d = CONFIRM;
`else
                        state_d = LOCKED;
                        gap_d   = '0;
                        emit    = 1'b1;
`endif
                    end
                end
`ifdef LVDS_RX_LOCK_CONFIRM_EN
                CONFIRM: begin
                    cnt_d = cnt_q + 5'd1;
                    if (boundary) begin
                        if (data_frame || end_frame) begin
                            state_d = LOCKED;
                            gap_d   = '0;
                            emit    = 1'b1;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
`endif
                LOCKED: begin
                    cnt_d = cnt_q + 5'd1;
                    if (boundary) begin
                        if (data_frame || end_frame) begin
                            gap_d = '0;
                            emit  = 1'b1;
                        end else if (zero_word) begin
                            gap_d = gap_inc;
                            if (gap_inc == GAP_W'(MAX_GAP_WORDS))
                                state_d = HUNT;
                        end else begin
                            state_d = HUNT;
                            err_d   = &err_q ? err_q : err_q + ERR_CNT_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        valid_d = emit && data_frame;
        end_d   = emit && end_frame;
        si_d    = valid_d ? sr_q[29:17] : si_q;
        sq_d    = valid_d ? sr_q[13:1] : sq_q;
    end
    // State, shifter, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
            sr_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            err_q   <= '0;
            si_q    <= '0;
            sq_q    <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            si_q    <= si_d;
            sq_q    <= sq_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end
endmodule

// File: tb/tb_lvds_iq_rx.sv
// tb_lvds_iq_rx: scoreboard bench for lvds_iq_rx (default build, no lock confirm)
module tb_lvds_iq_rx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        rx_data = 1'b0;
    logic [12:0] sample_i, sample_q;
    logic        sample_valid, msg_end, locked;
    logic [7:0]  sync_err_cnt;

    typedef struct {
        logic        is_end;
        logic [12:0] i;
        logic [12:0] q;
    } exp_t;

    exp_t        exp_q[$];
    int          vt[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [12:0] last_i = 13'd0;
    logic [12:0] last_q = 13'd0;

    lvds_iq_rx #(.MAX_GAP_WORDS(8), .ERR_CNT_W(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .rx_data(rx_data),
        .sample_i(sample_i),
        .sample_q(sample_q),
        .sample_valid(sample_valid),
        .msg_end(msg_end),
        .locked(locked),
        .sync_err_cnt(sync_err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && (sample_valid || msg_end)) begin
            if (sample_valid) vt.push_back(cyc);
            if (sample_valid && msg_end) begin
                check("strobes_exclusive", 32'({sample_valid, msg_end}), 32'b10);
            end else if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({sample_valid, msg_end}), 32'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", 32'(msg_end), 32'(e.is_end));
                check("sample_i", 32'(sample_i), 32'(e.i));
                check("sample_q", 32'(sample_q), 32'(e.q));
            end
        end
    end

    task automatic send_bit(input logic b);
        rx_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 31; k >= 0; k--) send_bit(w[k]);
    endtask

    task automatic send_data(input logic [12:0] i, input logic [12:0] q, input bit expect_out);
        if (expect_out) begin
            exp_q.push_back('{1'b0, i, q});
            last_i = i;
            last_q = q;
        end
        send_word({2'b10, i, 1'b1, 2'b01, q, 1'b0});
    endtask

    task automatic send_end();
        exp_q.push_back('{1'b1, last_i, last_q});
        send_word(32'h8000_4000);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_sample_i", 32'(sample_i), 32'h0);
        check("rst_sample_q", 32'(sample_q), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_msg_end", 32'(msg_end), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_err", 32'(sync_err_cnt), 32'h0);
        reset_n = 1'b1;
        // First frame locks and emits
        send_data(13'h0A5C, 13'h1234, 1'b1);
        send_bit(rx_data);
        check("lock_first", 32'(locked), 32'h1);
        // Resume on the boundary: the extra bit above must be the first bit of the next frame
        for (int k = 30; k >= 0; k--) send_bit(1'b0);
        // Realign: previous partial sequence was 32 bits: 1 + 31 bits, which counts as a word
        // Three frames separated by four zero words, 160 cycles apart
        vt.delete();
        send_data(13'h1FFF, 13'h0001, 1'b1);
        repeat (4) send_word(32'h0);
        send_data(13'h0001, 13'h1FFF, 1'b1);
        repeat (4) send_word(32'h0);
        send_data(13'h0AAA, 13'h1555, 1'b1);
        repeat (4) send_word(32'h0);
        check("gap_count", 32'(vt.size()), 32'd3);
        if (vt.size() == 3) begin
            check("gap_spacing_1", 32'(vt[1] - vt[0]), 32'd160);
            check("gap_spacing_2", 32'(vt[2] - vt[1]), 32'd160);
        end
        check("gap_locked", 32'(locked), 32'h1);
        check("gap_err", 32'(sync_err_cnt), 32'h0);
        // End-of-message frame
        send_end();
        send_word(32'h0);
        check("end_locked", 32'(locked), 32'h1);
        check("end_hold_i", 32'(sample_i), 32'h0AAA);
        // Bad word at a boundary
        send_word(32'hFFFF_FFFF);
        send_bit(1'b0);
        check("bad_unlock", 32'(locked), 32'h0);
        check("bad_err", 32'(sync_err_cnt), 32'h1);
        for (int k = 0; k < 31; k++) send_bit(1'b0);
        send_data(13'h0123, 13'h0456, 1'b1);
        send_word(32'h0);
        check("relock", 32'(locked), 32'h1);
        // Eight zero words drop lock without an error count
        repeat (7) send_word(32'h0);
        check("gap7_locked", 32'(locked), 32'h1);
        send_bit(1'b0);
        check("gap8_unlock", 32'(locked), 32'h0);
        check("gap8_err", 32'(sync_err_cnt), 32'h1);
        for (int k = 0; k < 31; k++) send_bit(1'b0);
        // 300 lock/error events saturate the counter
        for (int n = 0; n < 300; n++) begin
            send_data(13'(n), ~13'(n), 1'b1);
            send_word(32'h0000_0001);
        end
        send_word(32'h0);
        check("sat_err", 32'(sync_err_cnt), 32'hFF);
        check("sat_unlocked", 32'(locked), 32'h0);
        // Disable while locked, frames ignored, hunting resumes on re-enable
        send_data(13'h0F0F, 13'h00F0, 1'b1);
        send_bit(1'b0);
        enable = 1'b0;
        send_bit(1'b0);
        check("dis_unlock", 32'(locked), 32'h0);
        send_data(13'h1111, 13'h0222, 1'b0);
        send_word(32'h0);
        check("dis_err_kept", 32'(sync_err_cnt), 32'hFF);
        enable = 1'b1;
        send_data(13'h0BEE, 13'h0CAF, 1'b1);
        send_bit(1'b0);
        check("reen_locked", 32'(locked), 32'h1);
        // Mid-frame asynchronous reset
        for (int k = 0; k < 9; k++) send_bit(k[0]);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_i", 32'(sample_i), 32'h0);
        check("mid_rst_q", 32'(sample_q), 32'h0);
        check("mid_rst_locked", 32'(locked), 32'h0);
        check("mid_rst_err", 32'(sync_err_cnt), 32'h0);
        check("mid_rst_strobes", 32'({sample_valid, msg_end}), 32'h0);
        rx_data = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        send_data(13'h1357, 13'h0246, 1'b1);
        send_word(32'h0);
        check("post_rst_locked", 32'(locked), 32'h1);
        check("pending_expect", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lvds_iq_rx.md
Name: lvds_iq_rx

Overview:
- Serial I/Q frame receiver; the receive-side counterpart of the LVDS I/Q transmit path.
- Deserialises the single-lane SDR bit stream into 32-bit frames: {2'b10, I[12:0], 1'b1, 2'b01, Q[12:0], 1'b0}, MSB first.
- Finds frame alignment and emits I/Q sample pairs, end-of-message markers and lock/error status to downstream demod/RAM logic.
- Runs in the forwarded bit-clock domain.

Parameters:
- MAX_GAP_WORDS, 8: maximum consecutive all-zero words tolerated while locked before dropping lock.
- ERR_CNT_W, 8: width of the saturating sync-error counter.

Ports:
- clk  input  1  forwarded LVDS bit clock; rx_data sampled on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  receiver enable; low forces HUNT and holds outputs quiet.
- rx_data  input  1  serial data, MSB of frame first.
- sample_i  output  13  I sample of last valid data frame.
- sample_q  output  13  Q sample of last valid data frame.
- sample_valid  output  1  one-cycle strobe, sample_i/q updated.
- msg_end  output  1  one-cycle strobe, end-of-message frame received.
- locked  output  1  frame alignment held.
- sync_err_cnt  output  ERR_CNT_W  saturating count of alignment losses.

Behaviour:
- Reset (async, reset_n=0): shift register 0, bit counter 0, gap counter 0, state HUNT, sample_i=0, sample_q=0, sample_valid=0, msg_end=0, locked=0, sync_err_cnt=0.
- Shift register sr[31:0]: every clk, sr <= {sr[30:0], rx_data}. Shifting continues in every state, including while enable is low.
- sync_ok = sr[31:30]==2'b10 && sr[15:14]==2'b01 && sr[0]==0.
- Data frame: sync_ok && sr[16]==1. End frame: sync_ok && sr[16]==0 && sr[29:17]==0 && sr[13:1]==0. Zero word: sr==0.
- HUNT:
  - Evaluate on every cycle.
  - Data frame: emit sample, bit counter <= 0, state LOCKED, locked=1.
  - End frame: pulse msg_end, enter LOCKED.
  - Otherwise: stay in HUNT.
- LOCKED:
  - Bit counter increments mod 32. Evaluation only when the counter wraps to 31, i.e. 32 bits after the previous boundary.
  - Data frame: emit sample, gap counter <= 0.
  - End frame: msg_end pulse, gap counter <= 0.
  - Zero word: gap counter += 1. If the counter reaches MAX_GAP_WORDS: go to HUNT, locked=0; no error count.
  - Anything else: go to HUNT, locked=0, sync_err_cnt += 1, saturating at all-ones.
- Emit sample: sample_i <= sr[29:17], sample_q <= sr[13:1], sample_valid=1 for exactly one cycle.
- Latency: strobes and data are registered. They assert on the edge after the edge that captured frame bit 0.
- sample_i/q hold their value between strobes. They are never updated on an end frame or zero word.
- sample_valid and msg_end are mutually exclusive.
- enable=0: state HUNT, locked=0, strobes 0, counters held; sync_err_cnt is retained. On re-enable, hunting starts on the next cycle.
- Mid-frame reset: immediate clear. No partial frame is ever emitted.

Optional Feature:
- Macro: LVDS_RX_LOCK_CONFIRM_EN.
- Defined:
  - HUNT moves to CONFIRM on the first data frame or end frame, without emitting.
  - CONFIRM checks 32 bits later. A data or end frame there enters LOCKED and emits that frame. A zero word or bad word returns to HUNT with no error count.
  - locked asserts only in LOCKED.
  - Total latency to the first sample is +32 cycles.
- Undefined: the single-match lock described above; no CONFIRM state is synthesised.

Test Plan:
- Reset, then frame I=13'h0A5C, Q=13'h1234 (bit16=1, bit0=0) -> sample_valid one cycle after its last bit; sample_i=0A5C, sample_q=1234, locked=1.
- Three data frames, each separated by four zero words (MAX_GAP_WORDS=8) -> three sample_valid pulses exactly 160 cycles apart; locked stays 1; sync_err_cnt=0.
- Locked; send end frame {10,0,0,01,0,0} -> msg_end single pulse, no sample_valid, sample_i/q unchanged, still locked.
- Locked; inject word 32'hFFFF_FFFF at a boundary -> locked=0 next cycle, sync_err_cnt=1; next valid frame relocks and emits.
- Locked; send 8 zero words -> locked drops after the 8th word, sync_err_cnt unchanged. Drive 300 error events -> sync_err_cnt saturates at 8'hFF.
- With LVDS_RX_LOCK_CONFIRM_EN: frames A then B -> only B emitted, locked asserts at B. Assert reset_n low mid-frame -> all outputs 0 immediately.
